uart_i2c_usb_spi_wb_bridge: RTL and testbench

Wishbone-slave front end for the UART/I2C/USB/SPI peripheral cluster. It converts single Wishbone classic cycles from the system interconnect into the cluster's `reg_*` bus, one transaction at a time. It holds `reg_cs` until the peripheral acknowledges, then returns registered read data. It also rejects unmapped peripheral selects and ends hung accesses with a Wishbone error after a programmable timeout.

---
 rtl/uart_i2c_usb_spi_pkg.sv | 26 ++
 rtl/uart_i2c_usb_spi_wb_bridge.sv | 138 +++++++++++++
 tb/tb_uart_i2c_usb_spi_wb_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_i2c_usb_spi_pkg.sv
// Shared definitions for the UART/I2C/USB/SPI peripheral cluster and its Wishbone bridge.
// Peripheral selects are carried on byte-address bits [8:6].
package uart_i2c_usb_spi_pkg;

    localparam logic [2:0] SEL_UART0 = 3'd0;
    localparam logic [2:0] SEL_I2C   = 3'd1;
    localparam logic [2:0] SEL_USB   = 3'd2;
    localparam logic [2:0] SEL_SPI   = 3'd3;
    localparam logic [2:0] SEL_UART1 = 3'd4;

    // Writing this word with the top byte lane enabled clears the sticky error flag.
    localparam logic [31:0] ERR_CLEAR_KEY = 32'hC1EA_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } bridge_state_t;

    function automatic logic sel_is_mapped(input logic [2:0] sel);
        return (sel == SEL_UART0) || (sel == SEL_I2C) || (sel == SEL_USB) ||
               (sel == SEL_SPI) || (sel == SEL_UART1);
    endfunction

endpackage

// File: rtl/uart_i2c_usb_spi_wb_bridge.sv
// Wishbone classic slave that forwards one access at a time onto the cluster reg_* bus,
// with unmapped-select rejection and a saturating timeout for hung peripherals.
module uart_i2c_usb_spi_wb_bridge
    import uart_i2c_usb_spi_pkg::*;
#(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic        app_clk,
    input  logic        app_rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [8:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        reg_cs,
    output logic        reg_wr,
    output logic [8:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,
    output logic        err_flag_o,
    output logic [8:0]  err_addr_o
);

    bridge_state_t    state;
    bridge_state_t    state_next;
    logic [TMO_W-1:0] tmo_cnt;

    logic       strobe;
    logic       tmo_hit;
    logic       cs_d;
    logic       ack_d;
    logic       err_d;
    logic       accept;
    logic       capture;
    logic       clear_req;
    logic [8:0] err_addr_d;

    assign strobe  = wbs_cyc_i & wbs_stb_i;
    assign tmo_hit = (tmo_cnt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A peripheral ack beats the timeout, which beats a master abort.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (strobe) begin
                    state_next = sel_is_mapped(wbs_adr_i[8:6]) ? ST_REQ : ST_ERR;
                end
            end
            ST_REQ: begin
                if (reg_ack) begin
                    state_next = ST_DONE;
                end else if (tmo_hit) begin
                    state_next = ST_ERR;
                end else if (!wbs_cyc_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so every port comes straight off a flop.
    always_comb begin
        cs_d       = (state_next == ST_REQ);
        ack_d      = (state_next == ST_DONE);
        err_d      = (state_next == ST_ERR);
        accept     = (state == ST_IDLE) && strobe;
        capture    = (state == ST_REQ) && reg_ack && !reg_wr;
        clear_req  = accept && wbs_we_i && wbs_sel_i[3] && (wbs_dat_i == ERR_CLEAR_KEY);
        err_addr_d = (state == ST_IDLE) ? wbs_adr_i : reg_addr;
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            reg_cs     <= 1'b0;
            reg_wr     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_be     <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            wbs_dat_o  <= '0;
            err_flag_o <= 1'b0;
            err_addr_o <= '0;
        end else begin
            reg_cs    <= cs_d;
            wbs_ack_o <= ack_d;
            wbs_err_o <= err_d;
            if (accept) begin
                reg_wr    <= wbs_we_i;
                reg_addr  <= wbs_adr_i;
                reg_wdata <= wbs_dat_i;
                reg_be    <= wbs_sel_i;
            end
            if (err_d) begin
                wbs_dat_o <= '0;
            end else if (capture) begin
                wbs_dat_o <= reg_rdata;
            end
            // Setting the flag takes priority over a simultaneous clear.
            if (err_d) begin
                err_flag_o <= 1'b1;
                err_addr_o <= err_addr_d;
            end else if (clear_req) begin
                err_flag_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            tmo_cnt <= '0;
        end else if ((state != ST_REQ) && (state_next == ST_REQ)) begin
            tmo_cnt <= '0;
        end else if ((state == ST_REQ) && (tmo_cnt != '1)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_i2c_usb_spi_wb_bridge.sv
// Scoreboard bench for the Wishbone-to-reg bridge: the master pushes expected requests and
// responses, and a negedge monitor pops and compares whenever reg_cs rises or ack/err appears.
module tb_uart_i2c_usb_spi_wb_bridge;

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
        int          lat;
        int          issue;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [8:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  be;
    } req_t;

    logic        app_clk;
    logic        app_rst;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [8:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        reg_cs;
    logic        reg_wr;
    logic [8:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        err_flag_o;
    logic [8:0]  err_addr_o;

    int checks;
    int failures;
    int cycle;
    int cs_cycle;
    int cs_rises;
    int low_run;
    int last_gap;
    int last_pulse;
    int resp_count;
    int ack_delay;
    bit late_ack;
    bit cs_prev;
    logic [31:0] periph_rdata;

    resp_t resp_q[$];
    req_t  req_q[$];
    resp_t exp_resp;
    req_t  exp_req;

    uart_i2c_usb_spi_wb_bridge #(
        .TMO_W   (8),
        .TMO_CYC (200)
    ) dut (
        .app_clk    (app_clk),
        .app_rst    (app_rst),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_err_o  (wbs_err_o),
        .reg_cs     (reg_cs),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_be     (reg_be),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack),
        .err_flag_o (err_flag_o),
        .err_addr_o (err_addr_o)
    );

    initial app_clk = 1'b0;
    always #5 app_clk = ~app_clk;

    always @(posedge app_clk) cycle <= cycle + 1;

    // Peripheral model: ack arrives ack_delay cycles into the reg_cs pulse (0 = combinational).
    assign reg_rdata = periph_rdata;
    assign reg_ack   = late_ack | (reg_cs && (ack_delay >= 0) && (cs_cycle == ack_delay + 1));

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic unexpectedEvent(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got an event expected none", name);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge app_clk);
    endtask

    // Issues one classic cycle and holds strobe until ack or err, then releases it.
    task automatic applyStimulus(input bit we, input logic [8:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input bit exp_err,
                                 input logic [31:0] exp_dat, input int exp_lat);
        int waited;
        waited = 0;
        @(negedge app_clk);
        if (adr[8:6] <= 3'd4) begin
            req_q.push_back('{wr: we, adr: adr, wdat: dat, be: sel});
        end
        resp_q.push_back('{is_err: exp_err, dat: exp_dat, lat: exp_lat, issue: cycle});
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        while (1) begin
            @(negedge app_clk);
            waited++;
            if (wbs_ack_o || wbs_err_o) break;
            if (waited >= 400) begin
                checkOutput("response_timeout", 64'(waited), 64'(exp_lat));
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    // Starts a mapped access the peripheral never answers and returns after n reg_cs cycles.
    task automatic startHungAccess(input logic [8:0] adr, input int n);
        int seen;
        int waited;
        seen = 0;
        waited = 0;
        @(negedge app_clk);
        req_q.push_back('{wr: 1'b0, adr: adr, wdat: 32'h0, be: 4'hF});
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = adr;
        wbs_dat_i = 32'h0;
        wbs_sel_i = 4'hF;
        while ((seen < n) && (waited < 20)) begin
            @(negedge app_clk);
            waited++;
            if (reg_cs) seen++;
        end
        checkOutput("hung_cs_cycles", 64'(seen), 64'(n));
    endtask

    always @(negedge app_clk) begin
        if (!app_rst) begin
            if (reg_cs && !cs_prev) begin
                cs_rises++;
                last_gap = low_run;
                if (req_q.size() == 0) begin
                    unexpectedEvent("reg_request");
                end else begin
                    exp_req = req_q.pop_front();
                    checkOutput("req_wr", 64'(reg_wr), 64'(exp_req.wr));
                    checkOutput("req_addr", 64'(reg_addr), 64'(exp_req.adr));
                    checkOutput("req_wdata", 64'(reg_wdata), 64'(exp_req.wdat));
                    checkOutput("req_be", 64'(reg_be), 64'(exp_req.be));
                end
            end
            if (!reg_cs && cs_prev) last_pulse = cs_cycle;
            if (wbs_ack_o || wbs_err_o) begin
                resp_count++;
                checkOutput("ack_err_exclusive", 64'(wbs_ack_o & wbs_err_o), 64'(0));
                if (resp_q.size() == 0) begin
                    unexpectedEvent("wb_response");
                end else begin
                    exp_resp = resp_q.pop_front();
                    checkOutput("resp_is_err", 64'(wbs_err_o), 64'(exp_resp.is_err));
                    checkOutput("resp_data", 64'(wbs_dat_o), 64'(exp_resp.dat));
                    checkOutput("resp_latency", 64'(cycle - exp_resp.issue), 64'(exp_resp.lat));
                end
            end
        end
        low_run  = reg_cs ? 0 : low_run + 1;
        cs_cycle = reg_cs ? cs_cycle + 1 : 0;
        cs_prev  = reg_cs;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rc;
        int rises;
        checks = 0;
        failures = 0;
        cycle = 0;
        cs_cycle = 0;
        cs_rises = 0;
        low_run = 0;
        last_gap = 0;
        last_pulse = 0;
        resp_count = 0;
        ack_delay = -1;
        late_ack = 1'b0;
        cs_prev = 1'b0;
        periph_rdata = 32'h0;
        app_rst = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i = 1'b0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        wbs_sel_i = '0;

        repeat (3) @(posedge app_clk);
        #1;
        checkOutput("rst_reg_cs", 64'(reg_cs), 64'(0));
        checkOutput("rst_ack_err", 64'({wbs_ack_o, wbs_err_o}), 64'(0));
        checkOutput("rst_err_flag", 64'(err_flag_o), 64'(0));
        checkOutput("rst_dat_o", 64'(wbs_dat_o), 64'(0));
        checkOutput("rst_reg_bus", 64'({reg_wr, reg_addr, reg_be}), 64'(0));
        @(negedge app_clk);
        app_rst = 1'b0;

        $display("[TB] write to UART0, peripheral acks one cycle into reg_cs");
        ack_delay = 1;
        rises = cs_rises;
        applyStimulus(1'b1, 9'h004, 32'h0000_00A5, 4'hF, 1'b0, 32'h0, 3);
        idle(1);
        checkOutput("write_cs_pulses", 64'(cs_rises - rises), 64'(1));
        checkOutput("write_cs_len", 64'(last_pulse), 64'(2));

        $display("[TB] read with combinational ack");
        ack_delay = 0;
        periph_rdata = 32'h1234_5678;
        applyStimulus(1'b0, 9'h0C8, 32'h0, 4'hF, 1'b0, 32'h1234_5678, 2);

        $display("[TB] read of unmapped select 6");
        rises = cs_rises;
        applyStimulus(1'b0, 9'h180, 32'h0, 4'hF, 1'b1, 32'h0, 1);
        idle(1);
        checkOutput("unmapped_no_cs", 64'(cs_rises - rises), 64'(0));
        checkOutput("unmapped_flag", 64'(err_flag_o), 64'(1));
        checkOutput("unmapped_err_addr", 64'(err_addr_o), 64'(9'h180));

        $display("[TB] read of I2C with no ack, expecting timeout");
        ack_delay = -1;
        applyStimulus(1'b0, 9'h040, 32'h0, 4'hF, 1'b1, 32'h0, 201);
        idle(1);
        checkOutput("timeout_cs_len", 64'(last_pulse), 64'(200));
        checkOutput("timeout_err_addr", 64'(err_addr_o), 64'(9'h040));
        rc = resp_count;
        late_ack = 1'b1;
        idle(3);
        late_ack = 1'b0;
        idle(2);
        checkOutput("late_ack_no_resp", 64'(resp_count), 64'(rc));
        checkOutput("late_ack_dat_o", 64'(wbs_dat_o), 64'(0));

        $display("[TB] clear key without top byte lane, then with all lanes");
        ack_delay = 0;
        applyStimulus(1'b1, 9'h008, 32'hC1EA_0000, 4'h7, 1'b0, 32'h0, 2);
        idle(1);
        checkOutput("partial_key_flag", 64'(err_flag_o), 64'(1));
        applyStimulus(1'b1, 9'h008, 32'hC1EA_0000, 4'hF, 1'b0, 32'h0, 2);
        idle(1);
        checkOutput("clear_key_flag", 64'(err_flag_o), 64'(0));

        $display("[TB] back-to-back reads");
        periph_rdata = 32'h0000_1111;
        applyStimulus(1'b0, 9'h100, 32'h0, 4'hF, 1'b0, 32'h0000_1111, 2);
        periph_rdata = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 9'h0C0, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 2);
        idle(1);
        checkOutput("b2b_cs_gap", 64'(last_gap), 64'(2));
        checkOutput("b2b_cs_len", 64'(last_pulse), 64'(1));

        $display("[TB] unmapped write to select 7");
        applyStimulus(1'b1, 9'h1C0, 32'h0000_0005, 4'h3, 1'b1, 32'h0, 1);
        idle(1);
        checkOutput("unmapped_w_flag", 64'(err_flag_o), 64'(1));
        checkOutput("unmapped_w_addr", 64'(err_addr_o), 64'(9'h1C0));

        $display("[TB] master abort on third reg_cs cycle");
        ack_delay = -1;
        rc = resp_count;
        startHungAccess(9'h084, 3);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        idle(5);
        checkOutput("abort_cs_len", 64'(last_pulse), 64'(3));
        checkOutput("abort_no_resp", 64'(resp_count), 64'(rc));
        checkOutput("abort_cs_idle", 64'(reg_cs), 64'(0));

        $display("[TB] reset during a pending request");
        startHungAccess(9'h0C4, 2);
        app_rst = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(posedge app_clk);
        #1;
        checkOutput("midrst_reg_cs", 64'(reg_cs), 64'(0));
        checkOutput("midrst_reg_addr", 64'(reg_addr), 64'(0));
        checkOutput("midrst_reg_wdata_be", 64'({reg_wr, reg_be, reg_wdata}), 64'(0));
        checkOutput("midrst_flag", 64'(err_flag_o), 64'(0));
        checkOutput("midrst_err_addr", 64'(err_addr_o), 64'(0));
        checkOutput("midrst_wb_out", 64'({wbs_ack_o, wbs_err_o, wbs_dat_o}), 64'(0));
        @(negedge app_clk);
        app_rst = 1'b0;

        $display("[TB] recovery read after reset");
        ack_delay = 0;
        periph_rdata = 32'hA5A5_0001;
        applyStimulus(1'b0, 9'h004, 32'h0, 4'hF, 1'b0, 32'hA5A5_0001, 2);
        idle(3);
        checkOutput("resp_queue_drained", 64'(resp_q.size()), 64'(0));
        checkOutput("req_queue_drained", 64'(req_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
